// File: rtl/neuron_mac_acc.sv
// Per-neuron MAC: registered product, accumulate, add bias, hand the 22-bit
// pre-activation sum to the sigmoid stage. Define NEURON_SAT_EN to saturate out_sum.
module neuron_mac_acc #(
  parameter int NUM_INPUTS = 784,
  parameter int ACC_W      = 28
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_act,
  input  logic [7:0]  in_weight,
  input  logic [21:0] bias,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [21:0] out_sum
);

  localparam int CNT_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  typedef enum logic [1:0] {ACCUM, DRAIN, BIAS, OUT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               drain_cnt;
  logic               accept, last_beat, fire;
  logic               s1_vld;
  logic signed [17:0] prod_full;
  logic signed [16:0] prod;
  logic [ACC_W-1:0]   acc;
  logic [21:0]        sum_nxt;

  assign in_ready  = (state == ACCUM);
  assign accept    = in_valid && in_ready;
  assign last_beat = (cnt == CNT_W'(NUM_INPUTS - 1));
  assign fire      = out_valid && out_ready;
  assign prod_full = $signed({1'b0, in_act}) * $signed({in_weight[7], in_weight});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      s1_vld    <= 1'b0;
      prod      <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      s1_vld    <= accept;
      if (accept) begin
        prod <= prod_full[16:0];
        cnt  <= last_beat ? '0 : cnt + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt)           state_nxt = BIAS;
      BIAS:                             state_nxt = OUT;
      OUT:     if (fire)                state_nxt = ACCUM;
      default:                          state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (fire)
      acc <= '0;
    else if (state == BIAS)
      acc <= acc + {{(ACC_W-22){bias[21]}}, bias};
    else if (s1_vld)
      acc <= acc + {{(ACC_W-17){prod[16]}}, prod};
  end

`ifdef NEURON_SAT_EN
  localparam logic signed [ACC_W-1:0] SUM_MAX = ACC_W'(2097151);
  localparam logic signed [ACC_W-1:0] SUM_MIN = -ACC_W'(2097152);
  always_comb begin
    sum_nxt = acc[21:0];
    if ($signed(acc) > SUM_MAX)      sum_nxt = 22'h1FFFFF;
    else if ($signed(acc) < SUM_MIN) sum_nxt = 22'h200000;
  end
`else
  assign sum_nxt = acc[21:0];
`endif

  // First OUT cycle captures acc (bias already folded in); result is then
  // held until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (fire) begin
      out_valid <= 1'b0;
    end else if (state == OUT && !out_valid) begin
      out_valid <= 1'b1;
      out_sum   <= sum_nxt;
    end
  end

endmodule

// File: tb/tb_neuron_mac_acc.sv
// Scoreboard bench for neuron_mac_acc: a 4-input instance for directed
// neurons and a 784-input instance for the overflow case.
module tb_neuron_mac_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [7:0]  in_act, in_weight;
  logic [21:0] bias, out_sum;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [7:0]  b_in_act, b_in_weight;
  logic [21:0] b_bias, b_out_sum;

  int vectors = 0;
  int errors  = 0;
  logic [21:0] q[$];
  logic [21:0] bq[$];

  always #5 clk = ~clk;

  neuron_mac_acc #(.NUM_INPUTS(4), .ACC_W(28)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_act(in_act), .in_weight(in_weight), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum));

  neuron_mac_acc #(.NUM_INPUTS(784), .ACC_W(28)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_act(b_in_act), .in_weight(b_in_weight), .bias(b_bias),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop on handshake, and hold the front entry against out_sum
  // while the result is stalled.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) chk("unexpected_out", 32'(out_sum), 32'hDEAD);
      else if (out_ready) chk("out_sum", 32'(out_sum), 32'(q.pop_front()));
      else chk("out_sum_stall", 32'(out_sum), 32'(q[0]));
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (bq.size() == 0) chk("big_unexpected", 32'(b_out_sum), 32'hDEAD);
      else chk("big_out_sum", 32'(b_out_sum), 32'(bq.pop_front()));
    end
  end

  task automatic run_neuron(input logic [3:0][7:0] acts, input logic [3:0][7:0] wts,
                            input logic [21:0] b, input logic [21:0] exp,
                            input bit bubbles, input bit junk, input int hold);
    int lat;
    bias      = b;
    out_ready = (hold == 0);
    q.push_back(exp);
    for (int i = 0; i < 4; i++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid  = 1'b1;
      in_act    = acts[i];
      in_weight = wts[i];
      @(posedge clk); #1;
    end
    if (junk) begin
      in_act = 8'd255; in_weight = 8'd127;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    chk("in_ready_out", 32'(in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #1;
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_out_valid", 32'(out_valid), 32'd0);
  endtask

  localparam logic [3:0][7:0] ACT_B = {8'd40, 8'd30, 8'd20, 8'd10};
  localparam logic [3:0][7:0] WT_B  = {8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [3:0][7:0] ACT_N = {4{8'd255}};
  localparam logic [3:0][7:0] WT_N  = {4{8'h80}};
  localparam logic [3:0][7:0] ONES  = {4{8'd1}};

  initial begin
    int waitc;
    rst_n = 1'b0; in_valid = 1'b0; in_act = '0; in_weight = '0; bias = '0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_act = 8'd255; b_in_weight = 8'd127; b_bias = '0; b_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", 32'(out_sum), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_neuron(ACT_B, WT_B, 22'd5, 22'h000131, 1'b0, 1'b0, 0);
    run_neuron(ACT_N, WT_N, 22'd0, 22'h3E0200, 1'b0, 1'b0, 0);
    run_neuron(ACT_B, WT_B, 22'd5, 22'h000131, 1'b1, 1'b0, 5);
    run_neuron(ONES,  ONES, 22'd0, 22'h000004, 1'b0, 1'b0, 0);

    // Abandon a neuron after two beats with an async reset pulse.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_act = 8'd100; in_weight = 8'd100;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_out_sum", 32'(out_sum), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run_neuron(ACT_B, WT_B, 22'd5, 22'h000131, 1'b0, 1'b0, 0);

    run_neuron(ACT_B, WT_B, 22'd5, 22'h000131, 1'b0, 1'b1, 0);
    run_neuron(ACT_B, WT_B, 22'd5, 22'h000131, 1'b0, 1'b0, 0);

`ifdef NEURON_SAT_EN
    bq.push_back(22'h1FFFFF);
`else
    bq.push_back(22'h036B10);
`endif
    b_in_valid = 1'b1;
    repeat (784) begin
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    waitc = 0;
    while (bq.size() != 0 && waitc < 30) begin
      @(posedge clk); #1;
      waitc++;
    end
    chk("big_done", 32'(bq.size()), 32'd0);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/neuron_mac_acc.md
Name: neuron_mac_acc

Overview:
- Per-neuron multiply-accumulate stage that sits directly upstream of the sigmoid activation lookup.
- Consumes a stream of (activation, weight) pairs for one neuron.
- Adds the neuron bias and delivers one 22-bit signed pre-activation sum per neuron through a valid/ready handshake.
- The 22-bit output feeds the sigmoid lookup input directly; one instance per neuron, reused across images.

Parameters:
- NUM_INPUTS, 784, number of (activation, weight) beats per neuron result; must be ≥1.
- ACC_W, 28, internal accumulator width; must be ≥ 17 + clog2(NUM_INPUTS).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  activation/weight beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_act  input  8  activation, unsigned (pixel or previous-layer sigmoid output).
- in_weight  input  8  weight, two's complement signed.
- bias  input  22  neuron bias, signed, LSB-aligned with the product; sampled in BIAS state.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  22  signed pre-activation sum to the sigmoid stage.

Behaviour:
- Beat transfer: a beat transfers on a rising edge when in_valid && in_ready.
- Product:
  - in_act is zero-extended to 9 bits; in_weight is sign-extended to 9 bits.
  - 17-bit signed product is registered (stage 1).
  - Stage 2 adds the sign-extended product into acc[ACC_W-1:0].
  - A stage-1 valid bit gates stage 2; bubbles (in_valid low) do not disturb acc.
- Beat counter cnt counts accepted beats from 0 to NUM_INPUTS-1.
- FSM states:
  - ACCUM: in_ready=1. On the beat accepted with cnt==NUM_INPUTS-1, go to DRAIN and clear cnt.
  - DRAIN: in_ready=0, lasts exactly 2 cycles so the final product reaches acc. Then go to BIAS.
  - BIAS: in_ready=0, one cycle. acc <= acc + sign-extended bias. Go to OUT.
  - OUT: out_valid=1 and out_sum is held stable. On out_valid && out_ready, acc <= 0 and go to ACCUM; in_ready is 1 in the following cycle.
- Latency: out_valid rises on the 4th rising edge after the edge that accepted the final beat.
- out_sum is registered when entering OUT and derived from acc (see Optional Feature). It must not change while out_valid=1.
- in_valid asserted outside ACCUM is ignored; no beat is consumed.
- out_ready asserted outside OUT has no effect.
- Reset (rst_n low, asynchronous, any state including mid-accumulation):
  - state=ACCUM, cnt=0, acc=0, stage-1 valid=0.
  - out_valid=0, out_sum=0, in_ready=1 once released.
  - A partial neuron is discarded.
- NUM_INPUTS=1: the first accepted beat goes directly to DRAIN.
- No combinational path from out_ready to in_ready or from in_valid to out_valid.

Optional Feature:
- Macro: NEURON_SAT_EN.
- Defined: out_sum is acc saturated to the 22-bit signed range.
  - acc > 2097151 gives 0x1FFFFF.
  - acc < -2097152 gives 0x200000.
  - Otherwise out_sum = acc[21:0].
- Undefined: out_sum = acc[21:0] (wrap-around truncation), with no saturation logic.

Test Plan:
- Basic sum: NUM_INPUTS=4, acts 10,20,30,40, weights 1,2,3,4, bias 5, back-to-back beats -> out_sum=0x000131 (305); out_valid high exactly 4 edges after the last beat; in_ready=0 during DRAIN/BIAS/OUT.
- Negative sum: NUM_INPUTS=4, acts 255 ×4, weights -128 ×4, bias 0 -> out_sum=0x3E0200 (-130560), both builds.
- Overflow: NUM_INPUTS=784, all act 255, weight 127, bias 0 -> out_sum=0x1FFFFF with NEURON_SAT_EN defined; 0x036B10 (wrapped) without it.
- Bubbles plus backpressure: same data as the basic-sum test with in_valid toggling every other cycle, and out_ready held low 5 cycles in OUT -> out_sum stays 0x000131 throughout, in_ready stays 0. After the handshake, in_ready=1 the next cycle, and a second neuron (acts 1,1,1,1, weights 1,1,1,1, bias 0) yields 0x000004, proving acc was cleared.
- Reset mid-operation: NUM_INPUTS=4, accept 2 beats, pulse rst_n low for 1 cycle -> out_valid=0, out_sum=0. Then rerun the basic-sum stimulus -> 0x000131.
- Ignored input: in_valid held high with act 255, weight 127 during DRAIN/BIAS/OUT of the basic-sum test -> result still 0x000131; the next neuron's cnt starts at 0.
